// File: rtl/port_response_router_pkg.sv
// Shared encodings for the memory return path: the original port ids the
// request-side prioritizer tags onto each request, and the drop counter width.
package port_response_router_pkg;

    localparam int NUM_PORTS      = 3;
    localparam int RSP_DROP_CNT_W = 8;

    localparam logic [1:0] ORIG_PORT_1_ID = 2'b01;
    localparam logic [1:0] ORIG_PORT_2_ID = 2'b10;
    localparam logic [1:0] ORIG_PORT_3_ID = 2'b11;

    // One-hot port select for a pid; all zeros means the pid is illegal.
    function automatic logic [NUM_PORTS-1:0] pid_decode(input logic [1:0] pid);
        logic [NUM_PORTS-1:0] sel;
        sel    = '0;
        sel[0] = (pid == ORIG_PORT_1_ID);
        sel[1] = (pid == ORIG_PORT_2_ID);
        sel[2] = (pid == ORIG_PORT_3_ID);
        return sel;
    endfunction

endpackage

// File: rtl/port_response_router_resp_fifo.sv
// Per-port synchronous response FIFO. Push is refused while full and pop is
// ignored while empty, both judged on start-of-cycle occupancy. Data written
// this cycle is visible at the head only from the next cycle on.
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];
    assign w_push    = i_push & ~o_full;
    assign w_pop     = i_pop & ~o_empty;

    // Pointer/occupancy update; flush empties the FIFO and discards that cycle's push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop) r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/port_response_router.sv
// Steers tagged memory read responses back to ports 1/2/3, buffering each in
// a per-port FIFO until the port accepts it. Handshake: a transfer happens on
// any rising edge where valid and ready are both high; ready never depends
// combinationally on the consumer's ready (only on registered occupancy).
module port_response_router
    import port_response_router_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            rsp_data,
    input  logic                        rsp_valid,
    input  logic [1:0]                  rsp_orig_pid,
    output logic                        rsp_ready,
    output logic [WIDTH-1:0]            port1_rdata,
    output logic                        port1_rvalid,
    input  logic                        port1_rready,
    output logic [$clog2(DEPTH):0]      port1_level,
    output logic [WIDTH-1:0]            port2_rdata,
    output logic                        port2_rvalid,
    input  logic                        port2_rready,
    output logic [$clog2(DEPTH):0]      port2_level,
    output logic [WIDTH-1:0]            port3_rdata,
    output logic                        port3_rvalid,
    input  logic                        port3_rready,
    output logic [$clog2(DEPTH):0]      port3_level,
    output logic                        err_bad_pid,
    output logic [RSP_DROP_CNT_W-1:0]   drop_count
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [NUM_PORTS-1:0] w_sel;
    logic                 w_legal;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;
    logic [WIDTH-1:0]     w_rdata [NUM_PORTS];
    logic [LW-1:0]        w_level [NUM_PORTS];
    logic                 r_err_bad_pid;
    logic [RSP_DROP_CNT_W-1:0] r_drop_count;

    assign w_sel     = pid_decode(rsp_orig_pid);
    assign w_legal   = |w_sel;
    // Illegal pids are always accepted so they can be dropped without stalling.
    assign rsp_ready = w_legal ? ~|(w_sel & w_full) : 1'b1;
    assign w_push    = w_sel & {NUM_PORTS{rsp_valid & rsp_ready}};
    assign w_pop     = {port3_rready, port2_rready, port1_rready};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        resp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_flush     (flush),
            .i_push      (w_push[g]),
            .i_push_data (rsp_data),
            .i_pop       (w_pop[g]),
            .o_rd_data   (w_rdata[g]),
            .o_full      (w_full[g]),
            .o_empty     (w_empty[g]),
            .o_level     (w_level[g])
        );
    end

    assign port1_rdata  = w_rdata[0];
    assign port2_rdata  = w_rdata[1];
    assign port3_rdata  = w_rdata[2];
    assign port1_rvalid = ~w_empty[0];
    assign port2_rvalid = ~w_empty[1];
    assign port3_rvalid = ~w_empty[2];
    assign port1_level  = w_level[0];
    assign port2_level  = w_level[1];
    assign port3_level  = w_level[2];
    assign err_bad_pid  = r_err_bad_pid;
    assign drop_count   = r_drop_count;

    // Sticky error and saturating drop counter for bad-pid responses; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_bad_pid <= 1'b0;
            r_drop_count  <= '0;
        end else if (rsp_valid && !w_legal) begin
            r_err_bad_pid <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_port_response_router.sv
module tb_port_response_router;
  import port_response_router_pkg::*;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int LW = $clog2(D) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic [1:0]    pid;
  logic          rsp_ready;
  logic [2:0]    rr;
  wire  [W-1:0]  rd  [3];
  wire  [2:0]    rv;
  wire  [LW-1:0] lvl [3];
  wire           err;
  wire  [7:0]    drop;

  port_response_router #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .rsp_data     (rsp_data),
    .rsp_valid    (rsp_valid),
    .rsp_orig_pid (pid),
    .rsp_ready    (rsp_ready),
    .port1_rdata  (rd[0]),
    .port1_rvalid (rv[0]),
    .port1_rready (rr[0]),
    .port1_level  (lvl[0]),
    .port2_rdata  (rd[1]),
    .port2_rvalid (rv[1]),
    .port2_rready (rr[1]),
    .port2_level  (lvl[1]),
    .port3_rdata  (rd[2]),
    .port3_rvalid (rv[2]),
    .port3_rready (rr[2]),
    .port3_level  (lvl[2]),
    .err_bad_pid  (err),
    .drop_count   (drop)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] p, input logic [W-1:0] d, input logic [2:0] r);
    rsp_valid = v;
    pid       = p;
    rsp_data  = d;
    rr        = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- table of single-response vectors ----------------
  typedef struct {
    logic [1:0]   pid;
    logic [W-1:0] data;
    logic [2:0]   exp_mask;
    logic         exp_drop;
  } vec_t;
  vec_t tbl[6];

  // ---------------- scoreboard / reference model ----------------
  typedef logic [W-1:0] q_t[$];
  q_t mq[3];
  int mdrop;
  logic merr;

  int exp_drop;
  logic exp_ready;
  logic acc;
  int thr;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    rsp_valid = 1'b0;
    pid = 2'b00;
    rsp_data = '0;
    rr = 3'b000;
    #23;
    chk("reset_rvalid", {29'd0, rv}, 32'd0);
    chk("reset_lvl1", lvl[0], 0);
    chk("reset_rdata2", rd[1], 0);
    chk("reset_err", err, 0);
    chk("reset_drop", drop, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: single push to port 2, visible next cycle only.
    drive(1'b1, ORIG_PORT_2_ID, 8'hA5, 3'b000);
    chk("t1_ready", rsp_ready, 1);
    chk("t1_no_bypass", rv[1], 0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("t1_rvalid", {29'd0, rv}, 32'b010);
    chk("t1_rdata", rd[1], 8'hA5);
    chk("t1_lvl", lvl[1], 1);
    drive(1'b0, 2'b00, 8'h00, 3'b010);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("t1_popped", rv[1], 0);

    // Test 4a: single illegal pid.
    drive(1'b1, 2'b00, 8'hFF, 3'b000);
    chk("t4_ready", rsp_ready, 1);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("t4_err", err, 1);
    chk("t4_drop1", drop, 1);
    chk("t4_no_push", {29'd0, rv}, 0);
    exp_drop = 1;

    // Table-driven steering vectors.
    tbl[0] = '{ORIG_PORT_1_ID, 8'h3C, 3'b001, 1'b0};
    tbl[1] = '{ORIG_PORT_3_ID, 8'hC3, 3'b100, 1'b0};
    tbl[2] = '{2'b00,          8'h55, 3'b000, 1'b1};
    tbl[3] = '{ORIG_PORT_2_ID, 8'h7E, 3'b010, 1'b0};
    tbl[4] = '{ORIG_PORT_1_ID, 8'h00, 3'b001, 1'b0};
    tbl[5] = '{2'b00,          8'h81, 3'b000, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tbl[i].pid, tbl[i].data, 3'b000);
      chk("tbl_ready", rsp_ready, 1);
      tick();
      drive(1'b0, 2'b00, 8'h00, 3'b000);
      if (tbl[i].exp_drop) exp_drop++;
      chk("tbl_mask", {29'd0, rv}, {29'd0, tbl[i].exp_mask});
      for (int p = 0; p < 3; p++)
        if (tbl[i].exp_mask[p]) chk("tbl_data", rd[p], tbl[i].data);
      chk("tbl_drop", drop, exp_drop);
      drive(1'b0, 2'b00, 8'h00, 3'b111);
      tick();
      drive(1'b0, 2'b00, 8'h00, 3'b000);
      chk("tbl_drained", {29'd0, rv}, 0);
    end

    // Test 2: fill port 3, other ports still accepted.
    drive(1'b1, ORIG_PORT_3_ID, 8'h10, 3'b000);
    tick();
    drive(1'b1, ORIG_PORT_3_ID, 8'h11, 3'b000);
    tick();
    drive(1'b1, ORIG_PORT_3_ID, 8'h12, 3'b000);
    chk("t2_lvl3", lvl[2], 2);
    chk("t2_ready_full", rsp_ready, 0);
    tick();
    chk("t2_lvl3_hold", lvl[2], 2);
    chk("t2_head", rd[2], 8'h10);
    drive(1'b1, ORIG_PORT_1_ID, 8'h20, 3'b000);
    chk("t2_ready_p1", rsp_ready, 1);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("t2_lvl1", lvl[0], 1);
    chk("t2_rd1", rd[0], 8'h20);
    drive(1'b0, 2'b00, 8'h00, 3'b001);
    tick();

    // Test 3: full with simultaneous pop -> push still refused.
    drive(1'b1, ORIG_PORT_3_ID, 8'h12, 3'b100);
    chk("t3_ready_refused", rsp_ready, 0);
    tick();
    drive(1'b1, ORIG_PORT_3_ID, 8'h12, 3'b000);
    chk("t3_lvl_after_pop", lvl[2], 1);
    chk("t3_head11", rd[2], 8'h11);
    chk("t3_ready_now", rsp_ready, 1);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'b100);
    chk("t3_lvl2", lvl[2], 2);
    chk("t3_pop11", rd[2], 8'h11);
    tick();
    chk("t3_pop12", rd[2], 8'h12);
    chk("t3_lvl1", lvl[2], 1);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("t3_empty", rv[2], 0);

    // Test 4b: saturation of the drop counter.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'b00, W'(i), 3'b000);
      tick();
    end
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("t4_drop_sat", drop, 255);
    chk("t4_err_sticky", err, 1);

    // Test 5: flush with levels 2/1/2, flush-cycle push/pop discarded.
    drive(1'b1, ORIG_PORT_1_ID, 8'h31, 3'b000); tick();
    drive(1'b1, ORIG_PORT_1_ID, 8'h32, 3'b000); tick();
    drive(1'b1, ORIG_PORT_2_ID, 8'h33, 3'b000); tick();
    drive(1'b1, ORIG_PORT_3_ID, 8'h34, 3'b000); tick();
    drive(1'b1, ORIG_PORT_3_ID, 8'h35, 3'b000); tick();
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("t5_lvl1", lvl[0], 2);
    chk("t5_lvl2", lvl[1], 1);
    chk("t5_lvl3", lvl[2], 2);
    flush = 1'b1;
    drive(1'b1, ORIG_PORT_2_ID, 8'h77, 3'b111);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("t5_rvalid", {29'd0, rv}, 0);
    chk("t5_lvl1_0", lvl[0], 0);
    chk("t5_lvl2_0", lvl[1], 0);
    chk("t5_lvl3_0", lvl[2], 0);
    chk("t5_err", err, 1);
    chk("t5_drop", drop, 255);

    // Mid-operation asynchronous reset.
    drive(1'b1, ORIG_PORT_1_ID, 8'h99, 3'b000);
    tick();
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("mr_loaded", rv[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rvalid", {29'd0, rv}, 0);
    chk("mr_drop", drop, 0);
    chk("mr_err", err, 0);
    #3 rst_n = 1'b1;
    tick();

    // Test 6: random traffic against the queue model.
    mdrop = 0;
    merr  = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic v;
      logic [1:0] p;
      logic [W-1:0] d;
      logic [2:0] r;
      int sel;
      if (c % 1000 == 0) thr = $urandom_range(1, 4);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 7);
      p   = (sel == 0) ? 2'b00 : 2'((sel % 3) + 1);
      d   = W'($urandom);
      for (int i = 0; i < 3; i++) r[i] = ($urandom_range(0, 3) < thr);
      drive(v, p, d, r);
      exp_ready = (p == 2'b00) ? 1'b1 : (mq[p-1].size() < D);
      if (v) chk("rnd_ready", rsp_ready, exp_ready);
      for (int i = 0; i < 3; i++) begin
        chk("rnd_rvalid", rv[i], mq[i].size() > 0);
        chk("rnd_level", lvl[i], mq[i].size());
        if (mq[i].size() > 0) chk("rnd_rdata", rd[i], mq[i][0]);
      end
      acc = v && exp_ready;
      for (int i = 0; i < 3; i++)
        if (r[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (acc && p != 2'b00) mq[p-1].push_back(d);
      if (acc && p == 2'b00) begin
        merr = 1'b1;
        if (mdrop < 255) mdrop++;
      end
      tick();
      if (c % 500 == 499) chk("rnd_drop", drop, mdrop);
    end
    drive(1'b0, 2'b00, 8'h00, 3'b000);
    chk("rnd_final_drop", drop, mdrop);
    chk("rnd_final_err", err, merr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
